apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Two-requester APB master. Arbitrates round-robin between two local requesters and runs one APB transfer at a time on the shared bus to slave1/slave2.
- Decodes the slave from an address bit, inserts wait states per PREADY, reports PSLVERR, and aborts hung transfers after a timeout.
- Sits between on-chip initiators and the two apb_slave instances. It replaces direct poking of bus signals.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (PSTRB width = DATA_W/8)
- SEL_BIT, 12, address bit used for decode: 0 selects slave1, 1 selects slave2
- TIMEOUT, 16, maximum number of ACCESS cycles with PREADY low before abort (>=2)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous active-high reset
- req0/req1  in  1  transfer request, held until the matching done
- wr0/wr1  in  1  1=write, 0=read
- addr0/addr1  in  ADDR_W  transfer address
- wdata0/wdata1  in  DATA_W  write data
- strb0/strb1  in  DATA_W/8  byte strobes
- done0/done1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while done0/1 is high
- err  out  1  error flag (PSLVERR or timeout), valid with done
- tout  out  1  timeout flag, valid with done
- PSEL1/PSEL2  out  1  slave selects
- PENABLE  out  1  access phase
- PWRITE  out  1  direction
- PADDR  out  ADDR_W  address
- PWDATA  out  DATA_W  write data
- PSTRB  out  DATA_W/8  strobes (forced to 0 on reads)
- PRDATA1/PRDATA2  in  DATA_W  slave read data
- PREADY1/PREADY2  in  1  slave ready
- PSLVERR1/PSLVERR2  in  1  slave error

Behaviour:
- Reset (async, immediate):
  - All outputs go to 0.
  - FSM goes to IDLE, round-robin pointer to requester 0, wait counter to 0.
  - Reset mid-transfer drops PSEL/PENABLE at once. No done pulse is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Arbitration is suppressed in any cycle where done0 or done1 is high.
  - Otherwise, if any req is high: if only one is high, grant it. If both are high, grant the requester named by the pointer.
  - On a grant, latch wr/addr/wdata/strb of the winner and the decoded slave, then move to SETUP.
- SETUP (exactly 1 cycle):
  - Selected PSELx=1, PENABLE=0. PADDR, PWRITE, PWDATA, PSTRB driven from the latch.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE=1. PSELx and all bus fields stay stable.
  - Only the selected slave's PREADY, PRDATA and PSLVERR are used.
  - PREADY=1 completes the transfer.
  - PREADY=0 increments the wait counter. Abort when the counter reaches TIMEOUT-1 with PREADY still low.
- On completion or abort (same clock edge):
  - PSELx=0, PENABLE=0, next state IDLE.
  - done of the granted requester goes high for exactly 1 cycle.
  - Normal completion: rdata = captured PRDATA on reads, 0 on writes; err = PSLVERR; tout=0.
  - Abort: rdata=0, err=1, tout=1.
  - Pointer moves to the non-granted requester. Wait counter clears.
- Zero-wait latency: req high in IDLE at cycle N gives SETUP at N+1, ACCESS at N+2, done at N+3. Each wait state adds 1 cycle.
- Minimum spacing between transfers: 1 idle/done cycle. No back-to-back SETUP.
- A req that drops before it is granted is ignored. A req that drops mid-transfer does not cancel it; the done pulse is still issued.
- Requesters must deassert req no later than the cycle after done. A req still high then counts as a new request.
- PSEL1 and PSEL2 are never high together. PADDR/PWDATA/PSTRB hold their last values in IDLE.

Test Plan:
- Reset: PRESET pulsed mid-ACCESS -> PSEL1/PSEL2/PENABLE/done0/done1/err drop to 0 in the same cycle; the next request is granted to requester 0 first.
- Single write: req0, wr0=1, addr0=0x0000_0004, wdata0=0x1234_5678, strb0=4'b1111, zero-wait slave -> PSEL1 at N+1, PENABLE at N+2, done0 at N+3, err=0; slave1 register 0x4 reads back 0x1234_5678.
- Decode and read: req1 read of addr1=0x0000_1008 after a prior write of 0x8765_4321 -> PSEL2 only; done1 with rdata=0x8765_4321.
- Contention: req0 and req1 asserted in the same cycle, twice in a row -> grant order 0, 1, 0, 1; the done pulses never overlap.
- Wait states and error: PREADY held low for 3 ACCESS cycles, then high with PSLVERR=1 -> done at N+6, err=1, tout=0, PENABLE high for 4 cycles.
- Timeout: PREADY stuck low, TIMEOUT=16 -> ACCESS lasts 16 cycles, then PSEL/PENABLE drop; done with err=1, tout=1, rdata=0; the next request proceeds normally.

Source files
------------

// File: rtl/apb_rr_master_if.sv
// apb_rr_master_if: requester-side and APB-side signals of the two-requester APB master
interface apb_rr_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req0, req1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [DATA_W/8-1:0] strb0, strb1;
  logic done0, done1, err, tout;
  logic [DATA_W-1:0] rdata;
  logic PSEL1, PSEL2, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W/8-1:0] PSTRB;
  logic [DATA_W-1:0] PRDATA1, PRDATA2;
  logic PREADY1, PREADY2, PSLVERR1, PSLVERR2;
  modport master (
    input req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, strb0, strb1,
    input PRDATA1, PRDATA2, PREADY1, PREADY2, PSLVERR1, PSLVERR2,
    output done0, done1, err, tout, rdata,
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
  modport slave (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, strb0, strb1,
    output PRDATA1, PRDATA2, PREADY1, PREADY2, PSLVERR1, PSLVERR2,
    input done0, done1, err, tout, rdata,
    input PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbiter for two requesters driving one APB transfer at a time
// to two slaves, with wait-state handling, PSLVERR reporting and hung-transfer timeout.
module apb_rr_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_BIT = 12,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_rr_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t r_state;
  logic r_ptr, r_gnt, r_sel;
  logic [CW-1:0] r_cnt;
  logic w_gnt, w_wr, w_ready, w_slverr, w_abort;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, w_prdata;
  logic [DATA_W/8-1:0] w_strb;
  assign w_gnt    = (bus.req0 && bus.req1) ? r_ptr : bus.req1;
  assign w_wr     = w_gnt ? bus.wr1 : bus.wr0;
  assign w_addr   = w_gnt ? bus.addr1 : bus.addr0;
  assign w_wdata  = w_gnt ? bus.wdata1 : bus.wdata0;
  assign w_strb   = w_gnt ? bus.strb1 : bus.strb0;
  assign w_ready  = r_sel ? bus.PREADY2 : bus.PREADY1;
  assign w_slverr = r_sel ? bus.PSLVERR2 : bus.PSLVERR1;
  assign w_prdata = r_sel ? bus.PRDATA2 : bus.PRDATA1;
  assign w_abort  = !w_ready && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_gnt       <= 1'b0;
      r_sel       <= 1'b0;
      r_cnt       <= '0;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
      bus.err     <= 1'b0;
      bus.tout    <= 1'b0;
      bus.rdata   <= '0;
      bus.PSEL1   <= 1'b0;
      bus.PSEL2   <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
      bus.PSTRB   <= '0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.err   <= 1'b0;
      bus.tout  <= 1'b0;
      bus.rdata <= '0;
      case (r_state)
        IDLE: if (!bus.done0 && !bus.done1 && (bus.req0 || bus.req1)) begin
          r_gnt      <= w_gnt;
          r_sel      <= w_addr[SEL_BIT];
          bus.PSEL1  <= !w_addr[SEL_BIT];
          bus.PSEL2  <= w_addr[SEL_BIT];
          bus.PWRITE <= w_wr;
          bus.PADDR  <= w_addr;
          bus.PWDATA <= w_wdata;
          bus.PSTRB  <= w_wr ? w_strb : '0;
          r_state    <= SETUP;
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          r_state     <= ACCESS;
        end
        ACCESS: if (w_ready || w_abort) begin
          bus.PSEL1   <= 1'b0;
          bus.PSEL2   <= 1'b0;
          bus.PENABLE <= 1'b0;
          bus.done0   <= !r_gnt;
          bus.done1   <= r_gnt;
          bus.rdata   <= (w_ready && !bus.PWRITE) ? w_prdata : '0;
          bus.err     <= w_ready ? w_slverr : 1'b1;
          bus.tout    <= !w_ready;
          r_ptr       <= !r_gnt;
          r_cnt       <= '0;
          r_state     <= IDLE;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed bench with two behavioural APB slaves and hand-computed expectations
module tb_apb_rr_master;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int n_chk = 0;
  int n_bad = 0;
  apb_rr_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_rr_master #(.ADDR_W(32), .DATA_W(32), .SEL_BIT(12), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
  );
  always #5 PCLK = ~PCLK;
  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];
  int wn1 = 0, wn2 = 0, acc = 0;
  bit stk1 = 0, stk2 = 0, se1 = 0, se2 = 0;
  bit bad_overlap = 0;
  assign bus.PREADY1  = bus.PSEL1 && bus.PENABLE && !stk1 && (acc >= wn1);
  assign bus.PREADY2  = bus.PSEL2 && bus.PENABLE && !stk2 && (acc >= wn2);
  assign bus.PRDATA1  = mem1[bus.PADDR[5:2]];
  assign bus.PRDATA2  = mem2[bus.PADDR[5:2]];
  assign bus.PSLVERR1 = se1;
  assign bus.PSLVERR2 = se2;
  always @(posedge PCLK) begin
    acc <= bus.PENABLE ? acc + 1 : 0;
    for (int b = 0; b < 4; b++) begin
      if (bus.PWRITE && bus.PSTRB[b] && bus.PREADY1) mem1[bus.PADDR[5:2]][8*b+:8] <= bus.PWDATA[8*b+:8];
      if (bus.PWRITE && bus.PSTRB[b] && bus.PREADY2) mem2[bus.PADDR[5:2]][8*b+:8] <= bus.PWDATA[8*b+:8];
    end
  end
  always @(negedge PCLK) if ((bus.done0 && bus.done1) || (bus.PSEL1 && bus.PSEL2)) bad_overlap <= 1'b1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask
  logic s_psel1, s_psel2, s_pen;
  logic [31:0] s_paddr, s_pwdata;
  logic [3:0] s_pstrb;
  task automatic run_xfer(input bit who, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output int cyc, output int pen,
                          output logic [31:0] rd, output logic e, output logic t);
    bit got;
    got = 0; cyc = 0; pen = 0; rd = '0; e = 0; t = 0;
    if (who) begin
      bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = wd; bus.strb1 = st; bus.req1 = 1;
    end else begin
      bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = wd; bus.strb0 = st; bus.req0 = 1;
    end
    for (int c = 1; c <= 60 && !got; c++) begin
      tick;
      cyc = c;
      if (bus.PENABLE) pen++;
      if (c == 1) begin
        s_psel1 = bus.PSEL1; s_psel2 = bus.PSEL2; s_pen = bus.PENABLE;
        s_paddr = bus.PADDR; s_pwdata = bus.PWDATA; s_pstrb = bus.PSTRB;
      end
      if (who ? bus.done1 : bus.done0) begin
        got = 1; rd = bus.rdata; e = bus.err; t = bus.tout;
      end
    end
    if (!got) chk("xfer_timeout", 32'(got), 32'd1);
    bus.req0 = 0;
    bus.req1 = 0;
    tick;
  endtask
  int cyc, pen, who;
  logic [31:0] rd;
  logic e, t;
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 32'hA000_0000 + i;
      mem2[i] = 32'hB000_0000 + i;
    end
    mem2[4] = 32'hDEAD_BEEF;
    {bus.req0, bus.req1, bus.wr0, bus.wr1} = '0;
    {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1, bus.strb0, bus.strb1} = '0;
    tick; tick;
    PRESET = 0;
    tick;
    chk("rst_psel", {30'd0, bus.PSEL1, bus.PSEL2}, 32'd0);
    chk("rst_pen", 32'(bus.PENABLE), 32'd0);
    chk("rst_done", {30'd0, bus.done0, bus.done1}, 32'd0);
    chk("rst_err", {30'd0, bus.err, bus.tout}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    // zero-wait write from requester 0 to slave1
    run_xfer(0, 1, 32'h0000_0004, 32'h1234_5678, 4'hF, cyc, pen, rd, e, t);
    chk("wr_setup_sel", {30'd0, s_psel1, s_psel2}, 32'd2);
    chk("wr_setup_pen", 32'(s_pen), 32'd0);
    chk("wr_setup_addr", s_paddr, 32'h0000_0004);
    chk("wr_setup_wdata", s_pwdata, 32'h1234_5678);
    chk("wr_setup_strb", 32'(s_pstrb), 32'hF);
    chk("wr_latency", 32'(cyc), 32'd3);
    chk("wr_pen_cycles", 32'(pen), 32'd1);
    chk("wr_err", {30'd0, e, t}, 32'd0);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_mem1", mem1[1], 32'h1234_5678);
    // write to slave2, then read back via requester 1
    run_xfer(0, 1, 32'h0000_1008, 32'h8765_4321, 4'hF, cyc, pen, rd, e, t);
    chk("wr2_mem2", mem2[2], 32'h8765_4321);
    chk("wr2_mem1_untouched", mem1[2], 32'hA000_0002);
    run_xfer(1, 0, 32'h0000_1008, 32'h0, 4'hF, cyc, pen, rd, e, t);
    chk("rd_setup_sel", {30'd0, s_psel1, s_psel2}, 32'd1);
    chk("rd_setup_strb", 32'(s_pstrb), 32'h0);
    chk("rd_latency", 32'(cyc), 32'd3);
    chk("rd_rdata", rd, 32'h8765_4321);
    chk("rd_err", {30'd0, e, t}, 32'd0);
    // contention: both requesters every round, expect 0,1,0,1
    bus.wr0 = 1; bus.addr0 = 32'h0000_0010; bus.wdata0 = 32'h0000_0C00; bus.strb0 = 4'hF;
    bus.wr1 = 1; bus.addr1 = 32'h0000_1014; bus.wdata1 = 32'h0000_0C01; bus.strb1 = 4'hF;
    for (int r = 0; r < 2; r++) begin
      bus.req0 = 1; bus.req1 = 1;
      for (int k = 0; k < 2; k++) begin
        who = -1;
        for (int c = 0; c < 50 && who < 0; c++) begin
          tick;
          if (bus.done0) who = 0;
          else if (bus.done1) who = 1;
        end
        chk($sformatf("rr_order%0d", 2 * r + k), 32'(who), 32'(k));
        if (who == 0) bus.req0 = 0;
        else if (who == 1) bus.req1 = 0;
        else begin bus.req0 = 0; bus.req1 = 0; end
      end
      tick;
    end
    chk("rr_mem", mem1[4] ^ mem2[5], 32'h0000_0C00 ^ 32'h0000_0C01);
    // three wait states then PSLVERR
    wn1 = 3; se1 = 1;
    run_xfer(0, 0, 32'h0000_0004, 32'h0, 4'h0, cyc, pen, rd, e, t);
    chk("ws_latency", 32'(cyc), 32'd6);
    chk("ws_pen_cycles", 32'(pen), 32'd4);
    chk("ws_err_tout", {30'd0, e, t}, 32'd2);
    wn1 = 0; se1 = 0;
    // hung slave2: 16 ACCESS cycles, then abort
    stk2 = 1;
    run_xfer(0, 0, 32'h0000_1010, 32'h0, 4'h0, cyc, pen, rd, e, t);
    chk("to_latency", 32'(cyc), 32'd18);
    chk("to_pen_cycles", 32'(pen), 32'd16);
    chk("to_err_tout", {30'd0, e, t}, 32'd3);
    chk("to_rdata", rd, 32'd0);
    chk("to_bus_idle", {30'd0, bus.PSEL2, bus.PENABLE}, 32'd0);
    stk2 = 0;
    run_xfer(1, 1, 32'h0000_1018, 32'h5555_AAAA, 4'b0011, cyc, pen, rd, e, t);
    chk("post_to_latency", 32'(cyc), 32'd3);
    chk("post_to_err", {30'd0, e, t}, 32'd0);
    chk("post_to_strb", mem2[6], 32'hB000_AAAA);
    // async reset in the middle of ACCESS, pointer returns to requester 0
    run_xfer(0, 1, 32'h0000_0020, 32'h0000_0001, 4'hF, cyc, pen, rd, e, t);
    wn2 = 20;
    bus.wr1 = 0; bus.addr1 = 32'h0000_1000; bus.req1 = 1;
    tick; tick; tick;
    chk("pre_rst_access", {30'd0, bus.PSEL2, bus.PENABLE}, 32'd3);
    #2 PRESET = 1;
    #1;
    chk("mid_rst_bus", {29'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE}, 32'd0);
    chk("mid_rst_done", {29'd0, bus.done0, bus.done1, bus.err}, 32'd0);
    bus.req1 = 0; wn2 = 0;
    tick;
    PRESET = 0;
    bus.wr0 = 0; bus.addr0 = 32'h0000_0008; bus.req0 = 1;
    bus.req1 = 1;
    tick;
    chk("post_rst_grant", {29'd0, bus.PSEL1, bus.PSEL2, bus.done1}, 32'd4);
    tick; tick;
    chk("post_rst_done0", {30'd0, bus.done0, bus.done1}, 32'd2);
    chk("post_rst_rdata", bus.rdata, 32'hA000_0002);
    bus.req0 = 0;
    who = -1;
    for (int c = 0; c < 20 && who < 0; c++) begin
      tick;
      if (bus.done1) who = 1;
    end
    chk("post_rst_done1", 32'(who), 32'd1);
    bus.req1 = 0;
    tick;
    chk("no_overlap", 32'(bad_overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
